vehicle_detect: RTL

VEHICLE_DETECT -- requirements
Module: vehicle_detect

---
 rtl/vehicle_detect_pkg.sv | 17 +
 rtl/vehicle_detect_sensor_debounce.sv | 90 +++++++++
 rtl/vehicle_detect.sv | 73 +++++++
 3 files changed

// File: rtl/vehicle_detect_pkg.sv
// rtl/vehicle_detect_pkg.sv - shared state encoding and parameter defaults for vehicle_detect
package vehicle_detect_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } deb_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_DRAIN_CYCLES    = 3;
    localparam int DEF_THRESH          = 1;
    localparam int DEF_MAX_COUNT       = 15;
    localparam int TMR_W               = 8;

endpackage

// File: rtl/vehicle_detect_sensor_debounce.sv
// rtl/vehicle_detect_sensor_debounce.sv - loop sensor synchroniser and debounce FSM
module sensor_debounce
    import vehicle_detect_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic sensor_raw,
    output logic level,
    output logic rise
);

    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [TMR_W-1:0] cnt;
    logic [TMR_W-1:0] cnt_nxt;
    logic             rise_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= ST_LOW;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= sensor_raw;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
        end
    end

    // The sample that leaves a settled state counts as the first of the run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        case (state)
            ST_LOW: begin
                if (sync2) begin
                    state_nxt = ST_RISE_WAIT;
                    cnt_nxt   = 8'd1;
                end
            end
            ST_RISE_WAIT: begin
                if (!sync2) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt + 8'd1 >= DEB_LAST) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_HIGH: begin
                if (!sync2) begin
                    state_nxt = ST_FALL_WAIT;
                    cnt_nxt   = 8'd1;
                end
            end
            ST_FALL_WAIT: begin
                if (sync2) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt + 8'd1 >= DEB_LAST) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level = (state == ST_HIGH) || (state == ST_FALL_WAIT);

endmodule

// File: rtl/vehicle_detect.sv
// rtl/vehicle_detect.sv - side-road vehicle queue counter with drain timer and LTV flag
module vehicle_detect
    import vehicle_detect_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
    parameter int THRESH          = DEF_THRESH,
    parameter int MAX_COUNT       = DEF_MAX_COUNT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SENSOR_RAW,
    input  logic       L_GREEN,
    output logic       LTV,
    output logic [3:0] COUNT,
    output logic       VEH_PULSE,
    output logic       OVF
);

    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [3:0]       MAX_C      = 4'(MAX_COUNT);
    localparam logic [3:0]       THRESH_C   = 4'(THRESH);

    logic             deb_level;
    logic             deb_rise;
    logic             arrival;
    logic             drain;
    logic [TMR_W-1:0] drain_tmr;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK       (CLK),
        .RST       (RST),
        .sensor_raw(SENSOR_RAW),
        .level     (deb_level),
        .rise      (deb_rise)
    );

    assign VEH_PULSE = deb_rise;
    // An arrival is only counted while the debounced level agrees with it.
    assign arrival   = deb_rise & deb_level;
    assign drain     = L_GREEN && (COUNT != 4'd0) && (drain_tmr == DRAIN_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            drain_tmr <= '0;
            COUNT     <= 4'd0;
            LTV       <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            if (!L_GREEN || (COUNT == 4'd0) || drain) begin
                drain_tmr <= '0;
            end else begin
                drain_tmr <= drain_tmr + 8'd1;
            end

            // Arrival and drain together cancel, even at saturation.
            if (arrival && !drain) begin
                if (COUNT == MAX_C) begin
                    OVF <= 1'b1;
                end else begin
                    COUNT <= COUNT + 4'd1;
                end
            end else if (drain && !arrival) begin
                COUNT <= COUNT - 4'd1;
            end

            LTV <= (COUNT >= THRESH_C);
        end
    end

endmodule
